// File: rtl/hyperbus_rwds_calib.sv
// hyperbus_rwds_calib
// Automatic RWDS sampling-point calibration for the HyperBus PHY.
// The controller tries all eight candidate edges k = {idx[1:0], pol}. For each
// one it waits for the sampler config to settle, then runs NumTrials calibration
// reads and checks every RWDS sample. Finally it programs the centre of the
// longest contiguous passing window.
//
// Ports
//   clk_i, rst_ni       PHY clock, asynchronous active-low reset
//   start_i             start calibration (sampled only in IDLE)
//   expected_rwds_i     expected RWDS sample, captured at start
//   busy_o, done_o      in progress / one-cycle completion pulse
//   pass_o, pass_map_o  overall result / per-candidate result of the last run
//   cfg_edge_idx_o/pol_o  sampler edge configuration
//   trans_valid_o/ready_i   calibration read request handshake
//   trans_done_i, rwds_sample_i  transaction completion and its sample
//
// state  | meaning
// IDLE   | waiting for start_i; cfg holds the last chosen edge
// SETTLE | cfg just changed, let the sampler settle
// ISSUE  | request a calibration read, hold until accepted
// WAIT   | wait for the read to finish and check the sample
// EVAL   | record the candidate result, step to the next candidate
// SELECT | pick the centre of the longest passing window
// DONE   | completion pulse
module hyperbus_rwds_calib #(
  parameter int unsigned NumTrials    = 4,
  parameter int unsigned SettleCycles = 4,
  parameter logic [2:0]  DefaultEdge  = 3'd3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       expected_rwds_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] pass_map_o,
  output logic [1:0] cfg_edge_idx_o,
  output logic       cfg_edge_pol_o,
  output logic       trans_valid_o,
  input  logic       trans_ready_i,
  input  logic       trans_done_i,
  input  logic       rwds_sample_i
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, ISSUE, WAIT, EVAL, SELECT, DONE
  } state_t;

  localparam logic [3:0] SettleLoad = 4'(SettleCycles - 1);
  localparam logic [3:0] TrialLimit = 4'(NumTrials);

  state_t     state;
  logic [2:0] k_q;
  logic [2:0] cfg_q;
  logic [3:0] trial_q;
  logic [3:0] settle_q;
  logic       fail_q;
  logic       exp_q;
  logic [3:0] trial_nxt;

  assign cfg_edge_idx_o = cfg_q[2:1];
  assign cfg_edge_pol_o = cfg_q[0];
  assign trial_nxt      = trial_q + 4'd1;

  // Longest run of passing candidates, no wrap between bit 7 and bit 0.
  // A strictly-longer test keeps the earliest run on ties.
  logic [2:0] run_start, best_start, chosen;
  logic [3:0] run_len, best_len;

  always_comb begin
    run_start  = 3'd0;
    run_len    = 4'd0;
    best_start = 3'd0;
    best_len   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (pass_map_o[i]) begin
        if (run_len == 4'd0) run_start = 3'(i);
        run_len = run_len + 4'd1;
        if (run_len > best_len) begin
          best_len   = run_len;
          best_start = run_start;
        end
      end else begin
        run_len = 4'd0;
      end
    end
    if (best_len == 4'd0) chosen = DefaultEdge;
    else                  chosen = best_start + 3'((best_len - 4'd1) >> 1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      k_q           <= 3'd0;
      cfg_q         <= DefaultEdge;
      trial_q       <= 4'd0;
      settle_q      <= 4'd0;
      fail_q        <= 1'b0;
      exp_q         <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      pass_map_o    <= 8'h00;
      trans_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            exp_q      <= expected_rwds_i;
            k_q        <= 3'd0;
            cfg_q      <= 3'd0;
            trial_q    <= 4'd0;
            fail_q     <= 1'b0;
            pass_map_o <= 8'h00;
            pass_o     <= 1'b0;
            busy_o     <= 1'b1;
            settle_q   <= SettleLoad;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q == 4'd0) begin
            trans_valid_o <= 1'b1;
            state         <= ISSUE;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ISSUE: begin
          if (trans_ready_i) begin
            trans_valid_o <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (trans_done_i) begin
            if (rwds_sample_i != exp_q) fail_q <= 1'b1;
            trial_q <= trial_nxt;
            if (trial_nxt < TrialLimit) begin
              trans_valid_o <= 1'b1;
              state         <= ISSUE;
            end else begin
              state <= EVAL;
            end
          end
        end
        EVAL: begin
          pass_map_o[k_q] <= ~fail_q;
          fail_q          <= 1'b0;
          trial_q         <= 4'd0;
          if (k_q == 3'd7) begin
            state <= SELECT;
          end else begin
            k_q      <= k_q + 3'd1;
            cfg_q    <= k_q + 3'd1;
            settle_q <= SettleLoad;
            state    <= SETTLE;
          end
        end
        SELECT: begin
          cfg_q  <= chosen;
          pass_o <= |pass_map_o;
          done_o <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_rwds_calib.sv
// tb_hyperbus_rwds_calib
// Directed bench for hyperbus_rwds_calib with default parameters. A small PHY
// responder answers each request and returns a sample that is either the
// expected value or its inverse, chosen per candidate (and optionally per trial).
module tb_hyperbus_rwds_calib;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       expected_rwds_i = 1'b0;
  logic       busy_o, done_o, pass_o;
  logic [7:0] pass_map_o;
  logic [1:0] cfg_edge_idx_o;
  logic       cfg_edge_pol_o;
  logic       trans_valid_o;
  logic       trans_ready_i;
  logic       trans_done_i;
  logic       rwds_sample_i;

  hyperbus_rwds_calib dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .expected_rwds_i(expected_rwds_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .pass_map_o     (pass_map_o),
    .cfg_edge_idx_o (cfg_edge_idx_o),
    .cfg_edge_pol_o (cfg_edge_pol_o),
    .trans_valid_o  (trans_valid_o),
    .trans_ready_i  (trans_ready_i),
    .trans_done_i   (trans_done_i),
    .rwds_sample_i  (rwds_sample_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // responder controls
  logic       exp_v = 1'b0;
  logic [7:0] bad_mask = 8'h00;
  int         one_k = -1;
  int         one_trial = -1;
  int         ready_delay = 0;
  int         hs_cnt = 0;

  initial begin
    int wcnt = 0;
    int phase = 0;
    int tk = 0;
    int last_k = -1;
    int trial = 0;
    trans_ready_i = 1'b0;
    trans_done_i  = 1'b0;
    rwds_sample_i = 1'b0;
    forever begin
      @(negedge clk_i);
      trans_done_i = 1'b0;
      if (phase == 1) begin
        trans_ready_i = 1'b0;
        tk = int'({cfg_edge_idx_o, cfg_edge_pol_o});
        if (tk != last_k) trial = 0;
        last_k = tk;
        rwds_sample_i = exp_v ^ (bad_mask[tk] || (tk == one_k && trial == one_trial));
        trial++;
        trans_done_i = 1'b1;
        phase = 0;
        wcnt = 0;
      end else if (trans_valid_o) begin
        if (wcnt >= ready_delay) begin
          trans_ready_i = 1'b1;
          hs_cnt++;
          phase = 1;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // results of the last run
  int r_cyc, r_done, r_hs, r_vhi, r_fin, r_pm0, r_p0, r_sn, r_smin, r_smax;

  task automatic run_cal(input logic e, input logic [7:0] bm, input int ok, input int ot,
                         input int rd, input bit poke);
    int prev, cur, gap, hs0;
    bit meas;
    exp_v = e; bad_mask = bm; one_k = ok; one_trial = ot; ready_delay = rd;
    r_cyc = 0; r_done = 0; r_vhi = 0; r_fin = 0; r_sn = 0; r_smin = 999; r_smax = 0;
    meas = 1'b0; gap = 0;
    @(negedge clk_i);
    prev = int'({cfg_edge_idx_o, cfg_edge_pol_o});
    hs0 = hs_cnt;
    expected_rwds_i = e;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (c == 0) begin r_pm0 = int'(pass_map_o); r_p0 = int'(pass_o); end
      cur = int'({cfg_edge_idx_o, cfg_edge_pol_o});
      if (cur != prev) begin meas = 1'b1; gap = 0; end
      prev = cur;
      if (meas) begin
        if (trans_valid_o) begin
          r_sn++;
          if (gap < r_smin) r_smin = gap;
          if (gap > r_smax) r_smax = gap;
          meas = 1'b0;
        end else begin
          gap++;
        end
      end
      if (done_o) r_done++;
      if (trans_valid_o) r_vhi++;
      if (!busy_o) begin r_fin = 1; break; end
      r_cyc++;
      if (poke && c == 20) begin start_i = 1'b1; expected_rwds_i = ~e; end
      if (poke && c == 21) start_i = 1'b0;
      @(negedge clk_i);
    end
    r_hs = hs_cnt - hs0;
    chk("run_finished", r_fin, 1);
  endtask

  task automatic check_run(input string pre, input int pm, input int k, input int p,
                           input int cyc, input int vhi);
    chk({pre, "_pass_map"}, int'(pass_map_o), pm);
    chk({pre, "_cfg_k"}, int'({cfg_edge_idx_o, cfg_edge_pol_o}), k);
    chk({pre, "_pass"}, int'(pass_o), p);
    chk({pre, "_done_pulses"}, r_done, 1);
    chk({pre, "_handshakes"}, r_hs, 32);
    chk({pre, "_busy_cycles"}, r_cyc, cyc);
    chk({pre, "_valid_cycles"}, r_vhi, vhi);
  endtask

  initial begin
    int hs0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_pass", int'(pass_o), 0);
    chk("rst_pass_map", int'(pass_map_o), 0);
    chk("rst_valid", int'(trans_valid_o), 0);
    chk("rst_cfg_k", int'({cfg_edge_idx_o, cfg_edge_pol_o}), 3);
    rst_ni = 1'b1;

    // all pass -> full window 0..7, centre 3
    run_cal(1'b1, 8'h00, -1, -1, 0, 1'b0);
    check_run("allpass", 8'hFF, 3, 1, 106, 32);
    chk("allpass_settle_n", r_sn, 8);
    chk("allpass_settle_min", r_smin, 4);

    // fail on 0,1,7 -> window 2..6, centre 4
    run_cal(1'b0, 8'h83, -1, -1, 0, 1'b0);
    check_run("edges", 8'h7C, 4, 1, 106, 32);
    chk("edges_map_cleared", r_pm0, 0);
    chk("edges_pass_cleared", r_p0, 0);

    // all fail -> default edge, no pass
    run_cal(1'b1, 8'hFF, -1, -1, 0, 1'b0);
    check_run("allfail", 8'h00, 3, 0, 106, 32);

    // two equal runs {1,2} and {5,6} -> lowest start, centre 1
    run_cal(1'b0, 8'h99, -1, -1, 0, 1'b0);
    check_run("tie", 8'h66, 1, 1, 106, 32);

    // single mismatch on third trial of candidate 4 -> 0xEF, window 0..3, centre 1
    run_cal(1'b1, 8'h00, 4, 2, 0, 1'b0);
    check_run("single", 8'hEF, 1, 1, 106, 32);
    chk("single_settle_n", r_sn, 8);
    chk("single_settle_min", r_smin, 4);
    chk("single_settle_max", r_smax, 4);

    // ready held low 10 cycles per request; start and expected input disturbed mid-run
    run_cal(1'b1, 8'h00, -1, -1, 10, 1'b1);
    check_run("slowready", 8'hFF, 3, 1, 426, 352);

    // reset while waiting for a transaction
    @(negedge clk_i);
    exp_v = 1'b1; bad_mask = 8'h00; one_k = -1; one_trial = -1; ready_delay = 0;
    expected_rwds_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    hs0 = hs_cnt;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_i);
      #2;
      if (hs_cnt - hs0 >= 3) break;
    end
    chk("rwait_reached", hs_cnt - hs0, 3);
    chk("rwait_busy_before", int'(busy_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("rwait_busy", int'(busy_o), 0);
    chk("rwait_valid", int'(trans_valid_o), 0);
    chk("rwait_cfg_k", int'({cfg_edge_idx_o, cfg_edge_pol_o}), 3);
    chk("rwait_pass_map", int'(pass_map_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // recovers cleanly after the abort
    run_cal(1'b0, 8'h83, -1, -1, 0, 1'b0);
    check_run("after_rst", 8'h7C, 4, 1, 106, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
